// File: rtl/frame_sched_pkg.sv
// Shared types and 800x600 sync timing for the frame scheduler.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    DISPLAY,
    ARB,
    GRANT
  } state_e;

  localparam int unsigned HTOTAL  = 1040;
  localparam int unsigned VTOTAL  = 666;
  localparam int unsigned HSYNC   = 120;
  localparam int unsigned HBP     = 64;
  localparam int unsigned HACTIVE = 800;
  localparam int unsigned VSYNC   = 6;
  localparam int unsigned VBP     = 23;
  localparam int unsigned VACTIVE = 600;

  // eof fires on the last active pixel, so the front porch
  // contributes one extra cycle before the blank lines start.
  function automatic int unsigned blank_cycles();
    int unsigned hfp;
    hfp = HTOTAL - HACTIVE - HSYNC - HBP;
    return (hfp + 1)
         + (VTOTAL - VACTIVE) * HTOTAL
         + HSYNC + HBP;
  endfunction

endpackage

// File: rtl/frame_scheduler_rr_pick.sv
// Round-robin priority picker: first set req bit at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  logic          found;
  logic [IW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = IW'((32'(ptr_i) + i) % NREQ);
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Grants the sprite/state RAM update port to one requester at a time,
// only inside the vertical-blanking window.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned BLANK_CYCLES = blank_cycles(),
  parameter int unsigned GUARD        = 8,
  parameter int unsigned MAX_BURST    = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            eof,
  input  logic            sof,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  input  logic            clr_status,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            window,
  output logic            frame_tick,
  output logic [15:0]     frame_cnt,
  output logic [NREQ-1:0] overrun,
  output logic            late
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  localparam logic [16:0]   BLANK_LD = 17'(BLANK_CYCLES);
  localparam logic [16:0]   CLOSE_AT = 17'(GUARD + 1);
  localparam logic [BW-1:0] BURST_MX = BW'(MAX_BURST);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [16:0]     rem_q, rem_d;
  logic            tick_q, tick_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [NREQ-1:0] ovr_q, ovr_d;
  logic            late_q, late_d;
  logic            busy_q, win_q;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   nxt_ptr;
  logic [NREQ-1:0] ovr_set;
  logic            late_set;
  logic            closing;

  rr_pick #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_pick (
    .req_i(req),
    .ptr_i(ptr_q),
    .gnt_o(pick_oh),
    .idx_o(pick_idx)
  );

  assign nxt_ptr = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
  // Leaving after this cycle would land remaining at GUARD.
  assign closing = (rem_q <= CLOSE_AT) || sof;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    burst_d  = burst_q;
    rem_d    = (rem_q == '0) ? '0 : rem_q - 1'b1;
    tick_d   = 1'b0;
    cnt_d    = cnt_q;
    ovr_set  = '0;
    late_set = 1'b0;
    unique case (state_q)
      DISPLAY: begin
        if (eof && !sof) begin
          state_d = ARB;
          rem_d   = BLANK_LD;
          tick_d  = 1'b1;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      ARB: begin
        if (closing) begin
          state_d = DISPLAY;
        end else if (req != '0) begin
          state_d = GRANT;
          grant_d = pick_oh;
          gidx_d  = pick_idx;
          burst_d = BW'(1);
        end
      end
      GRANT: begin
        if (done[gidx_q]) begin
          state_d = ARB;
          grant_d = '0;
          burst_d = '0;
          ptr_d   = nxt_ptr;
        end else if (burst_q == BURST_MX) begin
          state_d         = ARB;
          grant_d         = '0;
          burst_d         = '0;
          ptr_d           = nxt_ptr;
          ovr_set[gidx_q] = 1'b1;
        end else if (closing) begin
          state_d  = DISPLAY;
          grant_d  = '0;
          burst_d  = '0;
          ptr_d    = nxt_ptr;
          late_set = 1'b1;
        end else begin
          burst_d = burst_q + 1'b1;
        end
      end
      default: state_d = DISPLAY;
    endcase
    ovr_d  = (ovr_q & ~{NREQ{clr_status}}) | ovr_set;
    late_d = (late_q & ~clr_status) | late_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DISPLAY;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      rem_q   <= '0;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
      ovr_q   <= '0;
      late_q  <= 1'b0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      rem_q   <= rem_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      late_q  <= late_d;
      busy_q  <= |grant_d;
      win_q   <= (state_d != DISPLAY);
    end
  end

  assign grant      = grant_q;
  assign busy       = busy_q;
  assign window     = win_q;
  assign frame_tick = tick_q;
  assign frame_cnt  = cnt_q;
  assign overrun    = ovr_q;
  assign late       = late_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed + randomized bench for frame_scheduler against a
// cycle-level model of the blanking-window grant rules.
module tb_frame_scheduler;

  localparam int N     = 4;
  localparam int BLANK = 100;
  localparam int GUARD = 8;
  localparam int MAXB  = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         eof = 1'b0;
  logic         sof = 1'b0;
  logic         clr_status = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] done = '0;
  logic [N-1:0] grant;
  logic         busy;
  logic         window;
  logic         frame_tick;
  logic [15:0]  frame_cnt;
  logic [N-1:0] overrun;
  logic         late;

  int checks = 0;
  int errors = 0;

  frame_scheduler #(
    .NREQ        (N),
    .BLANK_CYCLES(BLANK),
    .GUARD       (GUARD),
    .MAX_BURST   (MAXB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .eof       (eof),
    .sof       (sof),
    .req       (req),
    .done      (done),
    .clr_status(clr_status),
    .grant     (grant),
    .busy      (busy),
    .window    (window),
    .frame_tick(frame_tick),
    .frame_cnt (frame_cnt),
    .overrun   (overrun),
    .late      (late)
  );

  always #5 clk = ~clk;

  // Model: window open flag, cycles left in blanking, holder (-1 none).
  bit           m_open;
  int           m_left;
  int           m_holder;
  int           m_len;
  int           m_ptr;
  bit           m_tick;
  logic [15:0]  m_cnt;
  logic [N-1:0] m_ovr;
  bit           m_late;

  task automatic model_reset();
    m_open = 0; m_left = 0; m_holder = -1; m_len = 0;
    m_ptr = 0; m_tick = 0; m_cnt = '0; m_ovr = '0; m_late = 0;
  endtask

  task automatic model_step();
    bit           closing;
    int           nl;
    int           h;
    int           c;
    logic [N-1:0] ovs;
    bit           ls;
    closing = (m_left <= GUARD + 1) || sof;
    nl      = (m_left > 0) ? m_left - 1 : 0;
    m_tick  = 0;
    ovs     = '0;
    ls      = 0;
    if (!m_open) begin
      if (eof && !sof) begin
        m_open = 1; nl = BLANK; m_tick = 1; m_cnt = m_cnt + 16'd1;
      end
    end else if (m_holder < 0) begin
      if (closing) m_open = 0;
      else begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (m_holder < 0 && req[c]) begin
            m_holder = c; m_len = 1;
          end
        end
      end
    end else begin
      h = m_holder;
      if (done[h]) begin
        m_holder = -1; m_ptr = (h + 1) % N;
      end else if (m_len == MAXB) begin
        m_holder = -1; m_ptr = (h + 1) % N; ovs[h] = 1'b1;
      end else if (closing) begin
        m_holder = -1; m_ptr = (h + 1) % N; m_open = 0; ls = 1;
      end else m_len++;
    end
    m_left = nl;
    m_ovr  = (m_ovr & ~{N{clr_status}}) | ovs;
    m_late = (m_late && !clr_status) || ls;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    logic [N-1:0] eg;
    eg = '0;
    if (m_holder >= 0) eg[m_holder] = 1'b1;
    chk("grant", 32'(grant), 32'(eg));
    chk("busy", 32'(busy), 32'(eg != '0));
    chk("window", 32'(window), 32'(m_open));
    chk("frame_tick", 32'(frame_tick), 32'(m_tick));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("late", 32'(late), 32'(m_late));
  endtask

  task automatic tick();
    if (reset_n) model_step();
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic open_frame();
    eof = 1'b1; tick(); eof = 1'b0;
  endtask

  task automatic close_frame();
    for (int i = 0; i < 200 && window; i++) tick();
    chk("close_bound", 32'(window), 32'd0);
    sof = 1'b1; tick(); sof = 1'b0;
    tick();
  endtask

  task automatic clear_status();
    clr_status = 1'b1; tick(); clr_status = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int           wins, ticks, busys, nseen, run, idle, len;
  logic [N-1:0] order [4];
  int           gaps [3];
  logic [N-1:0] prev;
  logic [15:0]  cnt_before;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    reset_n = 1'b1;

    // 1: empty frame, window length and single tick
    repeat (9) tick();
    open_frame();
    wins = 0; ticks = 0; busys = 0;
    for (int i = 0; i < 110; i++) begin
      wins += int'(window);
      ticks += int'(frame_tick);
      busys += int'(busy);
      sof = (i == 99);
      tick();
    end
    sof = 1'b0;
    chk("t1_win_len", 32'(wins), 32'(BLANK - GUARD));
    chk("t1_ticks", 32'(ticks), 32'd1);
    chk("t1_busy", 32'(busys), 32'd0);
    chk("t1_cnt", 32'(frame_cnt), 32'd1);

    // 2: round-robin order, done on 3rd cycle, foreign done ignored
    req = 4'b1011;
    open_frame();
    nseen = 0; run = 0; idle = 0; prev = '0;
    for (int i = 0; i < 40; i++) begin
      if (grant != '0) begin
        if (prev == '0) begin
          if (nseen < 4) order[nseen] = grant;
          if (nseen > 0 && nseen < 4) gaps[nseen-1] = idle;
          nseen++;
          run = 1;
        end else run++;
        idle = 0;
      end else begin
        idle++;
        run = 0;
      end
      prev = grant;
      if (grant == '0) done = '0;
      else done = (run == 3) ? grant : ~grant;
      tick();
    end
    done = '0; req = '0;
    chk("t2_order0", 32'(order[0]), 32'b0001);
    chk("t2_order1", 32'(order[1]), 32'b0010);
    chk("t2_order2", 32'(order[2]), 32'b1000);
    chk("t2_order3", 32'(order[3]), 32'b0001);
    for (int g = 0; g < 3; g++) chk("t2_gap", 32'(gaps[g]), 32'd1);
    close_frame();

    // 3: burst cap and overrun
    clear_status();
    req = 4'b0100;
    open_frame();
    tick();
    len = 0;
    for (int i = 0; i < 40 && grant == 4'b0100; i++) begin
      len++; tick();
    end
    chk("t3_burst", 32'(len), 32'(MAXB));
    chk("t3_idle", 32'(grant), 32'd0);
    chk("t3_overrun", 32'(overrun), 32'b0100);
    tick();
    chk("t3_regrant", 32'(grant), 32'b0100);
    req = '0;
    close_frame();

    // 4: grant cut by window close at remaining=12
    clear_status();
    open_frame();
    repeat (87) tick();
    req = 4'b0010;
    tick();
    chk("t4_grant", 32'(grant), 32'b0010);
    len = 0;
    for (int i = 0; i < 20 && grant != '0; i++) begin
      len++; tick();
    end
    chk("t4_len", 32'(len), 32'd4);
    chk("t4_win", 32'(window), 32'd0);
    chk("t4_late", 32'(late), 32'd1);
    sof = 1'b1; tick(); sof = 1'b0;
    open_frame();
    tick();
    chk("t4_reopen", 32'(grant), 32'b0010);
    req = '0;
    done = 4'b0010; tick(); done = '0;
    close_frame();

    // 5: sof mid-grant, then eof+sof together
    clear_status();
    open_frame();
    repeat (43) tick();
    req = 4'b0001;
    tick();
    repeat (6) tick();
    chk("t5_pre", 32'(grant), 32'b0001);
    sof = 1'b1; tick(); sof = 1'b0;
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_win", 32'(window), 32'd0);
    chk("t5_late", 32'(late), 32'd1);
    req = '0;
    repeat (3) tick();
    cnt_before = frame_cnt;
    eof = 1'b1; sof = 1'b1; tick(); eof = 1'b0; sof = 1'b0;
    chk("t5_es_win", 32'(window), 32'd0);
    chk("t5_es_tick", 32'(frame_tick), 32'd0);
    chk("t5_es_cnt", 32'(frame_cnt), 32'(cnt_before));
    repeat (3) tick();
    chk("t5_es_win2", 32'(window), 32'd0);

    // 6: async reset mid-grant, clr vs set
    req = 4'b0001;
    open_frame();
    repeat (3) tick();
    chk("t6_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_grant", 32'(grant), 32'd0);
    chk("t6_win", 32'(window), 32'd0);
    chk("t6_cnt", 32'(frame_cnt), 32'd0);
    chk("t6_ovr", 32'(overrun), 32'd0);
    chk("t6_late", 32'(late), 32'd0);
    model_reset();
    req = '0;
    @(posedge clk);
    #1;
    chk_all();
    reset_n = 1'b1;
    req = 4'b0100;
    open_frame();
    tick();
    repeat (15) tick();
    chk("t6_hold", 32'(grant), 32'b0100);
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    chk("t6_setwins", 32'(overrun), 32'b0100);
    req = '0;
    close_frame();

    // Randomized frames against the model
    for (int f = 0; f < 12; f++) begin
      for (int t = 0; t < 130; t++) begin
        eof = (t == 0) || ($urandom_range(0, 99) == 0);
        sof = (t == 100) || ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 3) == 0) req = N'($urandom);
        done = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
        clr_status = ($urandom_range(0, 31) == 0);
        tick();
      end
    end
    eof = 1'b0; sof = 1'b0; req = '0; done = '0; clr_status = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
Shares the game-state/sprite RAM update port between NREQ game-logic requesters (players, bombs, explosions, ...). Grants are issued only inside the vertical-blanking window, so the pixel renderer never sees a half-updated frame.
- The window opens on the sync generator's end-of-frame pulse and closes GUARD cycles before the next start-of-frame.
- A start-of-frame pulse is a hard stop.
- Arbitration is round-robin, and each grant is capped at MAX_BURST cycles.

Parameters:
NREQ, 4, number of requesters (2..8)
BLANK_CYCLES, 68881, clk cycles from the eof pulse to the sof pulse (800x600 timing: 57 + 66*1040 + 184)
GUARD, 8, cycles before the expected sof at which the window closes
MAX_BURST, 16, maximum consecutive grant cycles per holder

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous, active-low reset
eof  in  1  1-cycle end-of-frame pulse from the sync generator
sof  in  1  1-cycle start-of-frame pulse from the sync generator
req  in  NREQ  request level per requester
done  in  NREQ  release pulse per requester; only the bit of the current holder is honoured
clr_status  in  1  clears the sticky status bits
grant  out  NREQ  one-hot grant, or zero
busy  out  1  high when grant is nonzero
window  out  1  high while the update window is open
frame_tick  out  1  1-cycle pulse on the cycle window rises
frame_cnt  out  16  frames seen; wraps 0xFFFF -> 0
overrun  out  NREQ  sticky, per requester: grant revoked by MAX_BURST
late  out  1  sticky: grant revoked by window close or sof

Behaviour:
- Reset state: DISPLAY. All outputs 0; rr pointer 0; remaining 0; burst counter 0. Reset asserted mid-grant drops grant asynchronously.
- All outputs are registered.
- remaining: 17-bit down-counter, loaded with BLANK_CYCLES on the cycle after eof, then decrements by 1 per cycle, saturating at 0.
- window = (state != DISPLAY), which holds while remaining > GUARD. The window is therefore high for exactly BLANK_CYCLES-GUARD cycles.
- States:
  - DISPLAY: on eof (and no sof in the same cycle) -> ARB next cycle. frame_tick=1 and frame_cnt+1 on that same next cycle. eof and sof together: stay in DISPLAY.
  - ARB: if the window is still open after this cycle and req != 0 -> GRANT next cycle. The chosen requester is the first set req bit scanning from ptr upward, mod NREQ. Grant latency from ARB is 1 cycle. If remaining <= GUARD+1 or sof -> DISPLAY.
  - GRANT, holding requester g; burst count starts at 1 in the first grant cycle. Checks in priority order:
    1. done[g]=1 -> ARB next cycle, grant=0, ptr=g+1.
    2. Burst count == MAX_BURST -> ARB next cycle, grant=0, overrun[g] set, ptr=g+1.
    3. Window close or sof -> DISPLAY next cycle, grant=0, late set, ptr=g+1.
- At least one idle cycle separates consecutive grants.
- A requester dropping req while granted does not release the grant; only done does.
- done bits other than the holder's are ignored.
- eof outside DISPLAY is ignored.
- clr_status and a new status set in the same cycle: the set wins.

Decomposition:
- Package frame_sched_pkg holds:
  - state enum {DISPLAY, ARB, GRANT};
  - timing constants HTOTAL=1040, VTOTAL=666, HSYNC=120, HBP=64, HACTIVE=800, VSYNC=6, VBP=23, VACTIVE=600;
  - a function deriving BLANK_CYCLES from those constants.
- Sub-module rr_pick: combinational round-robin priority picker. Inputs req and ptr; outputs a one-hot result and its index.

Test Plan:
Use BLANK_CYCLES=100, GUARD=8, MAX_BURST=16, NREQ=4 unless stated.
1. eof at cycle 10, no req -> window high cycles 11..102 (92 cycles); frame_tick only at 11; frame_cnt=1; grant stays 0.
2. req=0b1011 steady, each holder pulses done on its 3rd grant cycle -> grant order 0001, 0010, 1000, 0001; 1 idle cycle between grants.
3. req[2] only, never done -> grant=0100 for exactly 16 cycles; overrun=0100; req[2] re-granted after 1 idle cycle.
4. req[1] granted at remaining=12 with no done -> grant dropped the cycle window falls; late=1; next eof reopens and grants normally.
5. sof injected mid-grant at remaining=50 -> next cycle grant=0, window=0, late=1. eof+sof in the same cycle in DISPLAY -> no window opens.
6. Assert reset_n low mid-grant -> grant, window, frame_cnt and status all 0 immediately. clr_status while overrun sets -> bit remains set.
